gray_wptr_full: RTL and testbench
=================================

Name: gray_wptr_full

Overview:
- Write-side pointer generator for the asynchronous FIFO, performing binary-to-Gray encoding.
- Holds a binary write counter and drives the binary RAM write address.
- Publishes a registered Gray-coded write pointer for synchronisation into the read domain.
- Computes a registered full flag against the read pointer after that pointer has been synchronised into this domain. This block is the encoding end; the read side decodes Gray back to binary.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits (extra wrap bit).

Ports:
- wclk  input  1  write-domain clock; all state on rising edge.
- wrst_n  input  1  asynchronous, active-low reset.
- winc  input  1  write request; honoured only when wfull=0.
- wq2_rptr  input  ADDR_W+1  read pointer (Gray), already 2-flop synchronised into wclk.
- waddr  output  ADDR_W  binary RAM write address = wbin[ADDR_W-1:0].
- wptr  output  ADDR_W+1  registered Gray write pointer.
- wfull  output  1  registered full flag.
- wen  output  1  combinational write strobe to RAM = winc & ~wfull.

Behaviour:
- Reset (wrst_n=0, asynchronous, any time including mid-write): wbin=0, wptr=0, wfull=0; waddr=0. Clearing takes effect immediately, without waiting for a clock edge. Release is synchronous to the next wclk edge.
- wbin_next = wbin + (winc & ~wfull), modulo 2**(ADDR_W+1); wraps from all-ones to 0 with no special case.
- wgray_next = wbin_next ^ (wbin_next >> 1).
- Each wclk edge: wbin <= wbin_next; wptr <= wgray_next; wfull <= full_cond.
- Latency: a write accepted in cycle N updates waddr, wptr and wfull at edge N+1.
- full_cond: wgray_next == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]}, i.e. top two Gray bits inverted, rest equal.
- winc while wfull=1: ignored; pointer holds; wen=0; no overflow.
- wfull deasserts one cycle after wq2_rptr advances; it is pessimistic by the synchroniser delay, never optimistic.
- Gray property: consecutive wptr values differ in exactly one bit, including across the wrap from 2**(ADDR_W+1)-1 to 0. wptr never changes by more than one step per cycle.
- wptr is a flop output with no combinational path to the crossing, so it is safe to synchronise.
- X on winc during reset: no effect.

Decomposition:
- Shared package fifo_pkg:
  - ADDR_W default constant.
  - ptr_t typedef (logic [ADDR_W:0]).
  - bin2gray function.
  - full-compare function.
  - These are reused by the read-side empty logic.
- One natural sub-module: bin_to_gray, a pure combinational ADDR_W+1-bit encoder (dout = din ^ (din>>1)). It is instantiated here and is the inverse of the read-side Gray decoder.
- Counter and flag registers stay in this module.

Test Plan:
- Reset then idle: wrst_n low → wptr=5'b00000, waddr=0, wfull=0; hold winc=0 for 10 cycles → no change.
- Fill, wq2_rptr=0, winc=1 continuously:
  - wptr sequence 00001, 00011, 00010, 00110, …
  - after 16th accepted write: wptr=5'b11000, waddr=0, wfull=1.
  - 17th winc → wen=0, wptr unchanged.
- Drain release: from full, set wq2_rptr=5'b00001 → wfull=0 at next edge. One more write → wptr=5'b11001, wfull=1.
- Wrap-around: advance wq2_rptr alongside writes so the FIFO is never full, for 40 writes. Check wptr goes 5'b10000 → 5'b00000 at bin 31→0, and every transition has Hamming distance 1.
- Async reset mid-operation: at bin=9, pull wrst_n low between clock edges → wptr/waddr/wfull go to 0 before the next edge. Writing resumes from address 0 after release.
- Random stress: random winc and monotonically advancing legal wq2_rptr. Compare against a reference model; the write count never exceeds 16 beyond the read count.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer types and helpers, used by both the write-side
// full logic and the read-side empty logic.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 4;

    typedef logic [FIFO_ADDR_W:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Full when the next write pointer is exactly one lap ahead of the read pointer:
    // in Gray code that means the top two bits differ and the rest match.
    function automatic logic full_match(input ptr_t wgray_next, input ptr_t rgray_sync);
        return wgray_next == {~rgray_sync[FIFO_ADDR_W:FIFO_ADDR_W-1],
                              rgray_sync[FIFO_ADDR_W-2:0]};
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Pure combinational binary-to-Gray encoder; the read side holds the inverse decoder.
module bin_to_gray #(
    parameter int W = 5
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = din ^ (din >> 1);

endmodule

// File: rtl/gray_wptr_full.sv
// Write-side pointer of the async FIFO: binary counter for the RAM address,
// registered Gray pointer for the crossing, and registered full flag.
module gray_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              winc,
    input  logic [ADDR_W:0]   wq2_rptr,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              wfull,
    output logic              wen
);

    logic [ADDR_W:0] wbin_r;
    logic [ADDR_W:0] wptr_r;
    logic            wfull_r;
    logic [ADDR_W:0] wbin_next_s;
    logic [ADDR_W:0] wgray_next_s;
    logic [ADDR_W:0] rptr_lap_s;
    logic            full_cond_s;

    assign wen         = winc & ~wfull_r;
    assign wbin_next_s = wbin_r + {{ADDR_W{1'b0}}, wen};

    bin_to_gray #(
        .W (ADDR_W + 1)
    ) u_bin_to_gray (
        .din  (wbin_next_s),
        .dout (wgray_next_s)
    );

    // Read pointer as it would look one full lap behind the write pointer.
    assign rptr_lap_s  = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
    assign full_cond_s = (wgray_next_s == rptr_lap_s);

    // Pointer and flag registers; reset clears them without waiting for a clock.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_r  <= {(ADDR_W + 1){1'b0}};
            wptr_r  <= {(ADDR_W + 1){1'b0}};
            wfull_r <= 1'b0;
        end else begin
            wbin_r  <= wbin_next_s;
            wptr_r  <= wgray_next_s;
            wfull_r <= full_cond_s;
        end
    end

    assign waddr = wbin_r[ADDR_W-1:0];
    assign wptr  = wptr_r;
    assign wfull = wfull_r;

endmodule

// File: tb/tb_gray_wptr_full.sv
// Scoreboard bench for gray_wptr_full: stimulus pushes expected per-cycle
// results, an independent monitor samples the DUT and compares.
module tb_gray_wptr_full;

    localparam int AW = 4;

    logic          wclk;
    logic          wrst_n;
    logic          winc;
    logic [AW:0]   wq2_rptr;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          wen;

    gray_wptr_full #(.ADDR_W(AW)) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .wen      (wen)
    );

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr_pre;
        logic [AW:0]   wptr;
        logic [AW-1:0] waddr;
        logic          wfull;
        logic          ham;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [AW:0] m_bin;
    logic        m_full;
    logic        ham_ok;
    int          w_cnt;
    int          r_cnt;

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1);
    end

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] g2b(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; expected values come from a hand table when use_tbl is set.
    task automatic step(input logic inc, input logic [AW:0] rp,
                        input logic use_tbl, input logic [AW:0] tbl_ptr);
        exp_t        e;
        logic [AW:0] nb;
        logic [AW:0] diff;
        @(posedge wclk);
        #2;
        winc     = inc;
        wq2_rptr = rp;
        e.wen       = inc & ~m_full;
        e.waddr_pre = m_bin[AW-1:0];
        nb          = m_bin + {{AW{1'b0}}, e.wen};
        diff        = nb - g2b(rp);
        m_full      = (diff == 5'd16);
        m_bin       = nb;
        e.wptr      = use_tbl ? tbl_ptr : gray(nb);
        e.waddr     = nb[AW-1:0];
        e.wfull     = m_full;
        e.ham       = ham_ok;
        ham_ok      = 1'b1;
        if (e.wen) w_cnt++;
        q.push_back(e);
    endtask

    // Assert reset between clock edges and check that clearing is immediate.
    task automatic do_reset();
        @(posedge wclk);
        #3;
        wrst_n = 1'b0;
        winc   = 1'bx;
        #1;
        chk("rst_wptr",  {27'd0, wptr},  32'd0);
        chk("rst_waddr", {28'd0, waddr}, 32'd0);
        chk("rst_wfull", {31'd0, wfull}, 32'd0);
        @(posedge wclk);
        #2;
        winc   = 1'b0;
        wrst_n = 1'b1;
        m_bin  = 5'd0;
        m_full = 1'b0;
        ham_ok = 1'b0;
        w_cnt  = 0;
        r_cnt  = 0;
    endtask

    // Monitor: wen and address mid-cycle, registered outputs just after the edge.
    initial begin
        logic          s_wen;
        logic [AW-1:0] s_waddr_pre;
        logic [AW:0]   prev_wptr;
        exp_t          e;
        prev_wptr = 5'd0;
        forever begin
            @(negedge wclk);
            s_wen       = wen;
            s_waddr_pre = waddr;
            @(posedge wclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wen",       {31'd0, s_wen},       {31'd0, e.wen});
                chk("waddr_pre", {28'd0, s_waddr_pre}, {28'd0, e.waddr_pre});
                chk("wptr",      {27'd0, wptr},        {27'd0, e.wptr});
                chk("waddr",     {28'd0, waddr},       {28'd0, e.waddr});
                chk("wfull",     {31'd0, wfull},       {31'd0, e.wfull});
                if (e.ham)
                    chk("gray_step", $countones(prev_wptr ^ wptr), e.wen ? 32'd1 : 32'd0);
                prev_wptr = wptr;
            end
        end
    end

    logic [AW:0] fill_tbl [16];

    initial begin
        int n;
        fill_tbl = '{5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101,
                     5'b00100, 5'b01100, 5'b01101, 5'b01111, 5'b01110, 5'b01010,
                     5'b01011, 5'b01001, 5'b01000, 5'b11000};
        wrst_n   = 1'b1;
        winc     = 1'b0;
        wq2_rptr = 5'd0;
        m_bin    = 5'd0;
        m_full   = 1'b0;
        ham_ok   = 1'b0;
        w_cnt    = 0;
        r_cnt    = 0;

        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 1'b1, 5'b00000);

        // Fill to full with the reader parked at zero
        for (int i = 0; i < 16; i++) step(1'b1, 5'd0, 1'b1, fill_tbl[i]);
        step(1'b1, 5'd0, 1'b1, 5'b11000);

        // One read frees a slot; one write refills it
        step(1'b0, 5'b00001, 1'b1, 5'b11000);
        step(1'b1, 5'b00001, 1'b1, 5'b11001);

        // Reader keeps pace so the pointer wraps through 31 -> 0
        n = 0;
        while (n < 40) begin
            step(1'b1, gray(m_bin), 1'b0, 5'd0);
            if (q[q.size()-1].wen) n++;
        end

        // Async reset at bin 9, then resume from address 0
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 5'd0, 1'b0, 5'd0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 1'b0, 5'd0);

        // Random writes against a slower monotonic reader
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (r_cnt < w_cnt && $urandom_range(0, 1) == 0) r_cnt++;
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 gray(r_cnt[AW:0]), 1'b0, 5'd0);
        end

        repeat (3) @(posedge wclk);
        #2;
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
